// File: rtl/sha_pkg.sv
// Shared SHA-256 datapath definitions: block geometry, length width and the
// byte-packer state encoding used by sha_block_packer and the hash stages.
package sha_pkg;

    localparam int BLOCK_BITS  = 512;
    localparam int BLOCK_BYTES = 64;
    localparam int LEN_W       = 64;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        TAIL = 2'd2
    } packer_state_t;

endpackage

// File: rtl/sha_block_packer.sv
// Packs a valid/ready/last byte stream into MSB-first 512-bit blocks with bit
// length and last-block flag. Optional SHA_PACKER_MSG_BITS_EN adds m_msg_bits.
module sha_block_packer #(
    parameter int BLOCK_BYTES = 64,
    parameter int LEN_W       = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic [8*BLOCK_BYTES-1:0] m_block,
    output logic [LEN_W-1:0]         m_length,
    output logic                     m_last,
    output logic                     m_valid,
    input  logic                     m_ready
`ifdef SHA_PACKER_MSG_BITS_EN
    ,
    output logic [LEN_W-1:0]         m_msg_bits
`endif
);
    import sha_pkg::*;

    packer_state_t state;
    logic [5:0]    count;
    logic          pending_tail;
    logic [6:0]    nbytes;
    logic          accept;
    logic          block_done;
    logic          full_block;

    function automatic logic [LEN_W-1:0] bytes_to_bits(input logic [6:0] n);
        return LEN_W'(n) << 3;
    endfunction

    assign s_tready   = (state == FILL) && !rst;
    assign accept     = s_tvalid && s_tready;
    assign full_block = (count == 6'(BLOCK_BYTES - 1));
    assign block_done = accept && (full_block || s_tlast);
    assign nbytes     = {1'b0, count} + 7'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            count        <= '0;
            pending_tail <= 1'b0;
            m_block      <= '0;
            m_length     <= '0;
            m_last       <= 1'b0;
            m_valid      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        for (int i = 0; i < BLOCK_BYTES; i++) begin
                            if (count == i[5:0])
                                m_block[8*(BLOCK_BYTES-1-i) +: 8] <= s_tdata;
                        end
                        if (block_done) begin
                            // A message ending exactly on a block boundary still
                            // needs a zero-length last block behind the full one.
                            state        <= EMIT;
                            m_valid      <= 1'b1;
                            m_length     <= bytes_to_bits(nbytes);
                            m_last       <= s_tlast && !full_block;
                            pending_tail <= s_tlast && full_block;
                            count        <= '0;
                        end else begin
                            count <= count + 6'd1;
                        end
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        m_block <= '0;
                        if (pending_tail) begin
                            state        <= TAIL;
                            pending_tail <= 1'b0;
                            m_length     <= '0;
                            m_last       <= 1'b1;
                        end else begin
                            state   <= FILL;
                            m_valid <= 1'b0;
                        end
                    end
                end
                TAIL: begin
                    if (m_ready) begin
                        state   <= FILL;
                        m_valid <= 1'b0;
                        m_block <= '0;
                    end
                end
                default: begin
                    state   <= FILL;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHA_PACKER_MSG_BITS_EN
    function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a,
                                                 input logic [LEN_W-1:0] b);
        logic [LEN_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[LEN_W] ? '1 : sum[LEN_W-1:0];
    endfunction

    // Running total accumulates as each block is formed; cleared once the
    // message's last block has been handed off.
    always_ff @(posedge clk) begin
        if (rst)
            m_msg_bits <= '0;
        else if (block_done)
            m_msg_bits <= sat_add(m_msg_bits, bytes_to_bits(nbytes));
        else if (m_valid && m_ready && m_last)
            m_msg_bits <= '0;
    end
`endif

endmodule
